// File: rtl/jelly_wishbone_master_sequencer.sv
// ---------------------------------------------------------------------------
// jelly_wishbone_master_sequencer
//
// Runs one command at a time as a Wishbone single-access master. A command
// is a write, a read, or a poll. A poll repeats a read until the masked data
// matches the expected value, or until the retry limit is reached. Each
// command returns exactly one response. An optional idle delay follows that
// response.
//
// Ports
//   aresetn, aclk      : asynchronous active-low reset, clock
//   s_cmd_*            : command channel (valid/ready)
//                        mode 0=write, 1=read, 2=poll, 3=read
//   m_rsp_*            : response channel (valid/ready); the fields are held
//                        until the handshake
//   m_wb_*             : Wishbone master (adr/dat/sel/we/stb out, dat/ack in)
//   busy               : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module jelly_wishbone_master_sequencer #(
    parameter int WB_ADR_WIDTH = 37,
    parameter int WB_DAT_WIDTH = 64,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int TIMEOUT      = 1024,
    parameter int WAIT_WIDTH   = 16,
    parameter int POLL_WIDTH   = 16
) (
    input  logic                    aresetn,
    input  logic                    aclk,

    input  logic [1:0]              s_cmd_mode,
    input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
    input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
    input  logic [WB_DAT_WIDTH-1:0] s_cmd_mask,
    input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
    input  logic [WAIT_WIDTH-1:0]   s_cmd_wait,
    input  logic [POLL_WIDTH-1:0]   s_cmd_poll,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,

    output logic [WB_DAT_WIDTH-1:0] m_rsp_dat,
    output logic                    m_rsp_we,
    output logic                    m_rsp_timeout,
    output logic                    m_rsp_poll_fail,
    output logic [POLL_WIDTH-1:0]   m_rsp_count,
    output logic                    m_rsp_valid,
    input  logic                    m_rsp_ready,

    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_we_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i,

    output logic                    busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BUS  = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT);

    logic [2:0]              r_state;
    logic [1:0]              r_mode;
    logic [WB_DAT_WIDTH-1:0] r_mask;
    logic [WAIT_WIDTH-1:0]   r_wait;
    logic [WAIT_WIDTH-1:0]   r_wait_cnt;
    logic [POLL_WIDTH-1:0]   r_limit;
    logic [POLL_WIDTH-1:0]   r_count;
    logic [TMO_W-1:0]        r_tmo;
    logic [WB_DAT_WIDTH-1:0] r_rdat;

    logic                    w_is_write;
    logic                    w_is_poll;
    logic                    w_match;
    logic [POLL_WIDTH-1:0]   w_count_inc;

    assign w_is_write  = (r_mode == 2'd0);
    assign w_is_poll   = (r_mode == 2'd2);
    // m_wb_dat_o holds the expected value while a poll is running.
    assign w_match     = ((m_wb_dat_i & r_mask) == (m_wb_dat_o & r_mask));
    assign w_count_inc = r_count + POLL_WIDTH'(1);

    assign s_cmd_ready = (r_state == ST_IDLE) & aresetn;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= ST_IDLE;
            r_mode          <= '0;
            r_mask          <= '0;
            r_wait          <= '0;
            r_wait_cnt      <= '0;
            r_limit         <= '0;
            r_count         <= '0;
            r_tmo           <= '0;
            r_rdat          <= '0;
            m_wb_adr_o      <= '0;
            m_wb_dat_o      <= '0;
            m_wb_sel_o      <= '0;
            m_wb_we_o       <= 1'b0;
            m_wb_stb_o      <= 1'b0;
            m_rsp_dat       <= '0;
            m_rsp_we        <= 1'b0;
            m_rsp_timeout   <= 1'b0;
            m_rsp_poll_fail <= 1'b0;
            m_rsp_count     <= '0;
            m_rsp_valid     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_cmd_valid) begin
                        r_mode     <= s_cmd_mode;
                        m_wb_adr_o <= s_cmd_adr;
                        m_wb_dat_o <= s_cmd_dat;
                        m_wb_sel_o <= (s_cmd_mode == 2'd0) ? s_cmd_sel : '1;
                        m_wb_we_o  <= (s_cmd_mode == 2'd0);
                        r_mask     <= s_cmd_mask;
                        r_wait     <= s_cmd_wait;
                        r_limit    <= (s_cmd_poll == '0) ? POLL_WIDTH'(1) : s_cmd_poll;
                        r_count    <= '0;
                        r_rdat     <= '0;
                        r_tmo      <= TMO_LOAD;
                        m_wb_stb_o <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (m_wb_ack_i) begin
                        m_wb_stb_o <= 1'b0;
                        r_count    <= w_count_inc;
                        if (!w_is_write) begin
                            r_rdat <= m_wb_dat_i;
                        end
                        if (w_is_poll && !w_match && (w_count_inc != r_limit)) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state         <= ST_RESP;
                            m_rsp_valid     <= 1'b1;
                            m_rsp_dat       <= w_is_write ? '0 : m_wb_dat_i;
                            m_rsp_we        <= w_is_write;
                            m_rsp_timeout   <= 1'b0;
                            m_rsp_poll_fail <= w_is_poll && !w_match;
                            m_rsp_count     <= w_count_inc;
                        end
                    end else if (TIMEOUT > 0) begin
                        // r_tmo is loaded with TIMEOUT on entry, so the value 1
                        // marks the last cycle that is allowed to go without an ack.
                        if (r_tmo == TMO_W'(1)) begin
                            m_wb_stb_o      <= 1'b0;
                            r_state         <= ST_RESP;
                            m_rsp_valid     <= 1'b1;
                            m_rsp_dat       <= w_is_write ? '0 : r_rdat;
                            m_rsp_we        <= w_is_write;
                            m_rsp_timeout   <= 1'b1;
                            m_rsp_poll_fail <= 1'b0;
                            m_rsp_count     <= r_count;
                        end else begin
                            r_tmo <= r_tmo - TMO_W'(1);
                        end
                    end
                end

                ST_GAP: begin
                    m_wb_stb_o <= 1'b1;
                    r_tmo      <= TMO_LOAD;
                    r_state    <= ST_BUS;
                end

                ST_RESP: begin
                    if (m_rsp_ready) begin
                        m_rsp_valid <= 1'b0;
                        if (r_wait != '0) begin
                            r_wait_cnt <= r_wait;
                            r_state    <= ST_WAIT;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_WIDTH'(1)) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_WIDTH'(1);
                    end
                end

                default: begin
                    m_wb_stb_o  <= 1'b0;
                    m_rsp_valid <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jelly_wishbone_master_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jelly_wishbone_master_sequencer
//
// Testbench for jelly_wishbone_master_sequencer, built with TIMEOUT=16.
// Directed commands come first, then randomized ones. A task-driven Wishbone
// slave answers after a configurable latency and returns data from rd_seq.
// Each response is checked against an outcome computed directly from the
// command rules.
// ---------------------------------------------------------------------------
module tb_jelly_wishbone_master_sequencer;

    logic        aresetn;
    logic        aclk;
    logic [1:0]  s_cmd_mode;
    logic [36:0] s_cmd_adr;
    logic [63:0] s_cmd_dat;
    logic [63:0] s_cmd_mask;
    logic [7:0]  s_cmd_sel;
    logic [15:0] s_cmd_wait;
    logic [15:0] s_cmd_poll;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [63:0] m_rsp_dat;
    logic        m_rsp_we;
    logic        m_rsp_timeout;
    logic        m_rsp_poll_fail;
    logic [15:0] m_rsp_count;
    logic        m_rsp_valid;
    logic        m_rsp_ready;
    logic [36:0] m_wb_adr_o;
    logic [63:0] m_wb_dat_i;
    logic [63:0] m_wb_dat_o;
    logic [7:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i;
    logic        busy;

    int          tests;
    int          fails;
    logic [63:0] rd_seq [16];
    bit          spurious;

    jelly_wishbone_master_sequencer #(
        .WB_ADR_WIDTH (37),
        .WB_DAT_WIDTH (64),
        .WB_SEL_WIDTH (8),
        .TIMEOUT      (16),
        .WAIT_WIDTH   (16),
        .POLL_WIDTH   (16)
    ) u_dut (
        .aresetn         (aresetn),
        .aclk            (aclk),
        .s_cmd_mode      (s_cmd_mode),
        .s_cmd_adr       (s_cmd_adr),
        .s_cmd_dat       (s_cmd_dat),
        .s_cmd_mask      (s_cmd_mask),
        .s_cmd_sel       (s_cmd_sel),
        .s_cmd_wait      (s_cmd_wait),
        .s_cmd_poll      (s_cmd_poll),
        .s_cmd_valid     (s_cmd_valid),
        .s_cmd_ready     (s_cmd_ready),
        .m_rsp_dat       (m_rsp_dat),
        .m_rsp_we        (m_rsp_we),
        .m_rsp_timeout   (m_rsp_timeout),
        .m_rsp_poll_fail (m_rsp_poll_fail),
        .m_rsp_count     (m_rsp_count),
        .m_rsp_valid     (m_rsp_valid),
        .m_rsp_ready     (m_rsp_ready),
        .m_wb_adr_o      (m_wb_adr_o),
        .m_wb_dat_i      (m_wb_dat_i),
        .m_wb_dat_o      (m_wb_dat_o),
        .m_wb_sel_o      (m_wb_sel_o),
        .m_wb_we_o       (m_wb_we_o),
        .m_wb_stb_o      (m_wb_stb_o),
        .m_wb_ack_i      (m_wb_ack_i),
        .busy            (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command, act as the slave, and check the response.
    // Expected outcome: a write or read is one access. A poll succeeds on the
    // first rd_seq entry that matches under the mask, or fails once the limit
    // is reached. A slave that never acks gives a timeout after 16 cycles.
    task automatic do_cmd(input logic [1:0] mode, input logic [36:0] adr,
                          input logic [63:0] dat, input logic [63:0] mask,
                          input logic [7:0] sel, input logic [15:0] wt,
                          input logic [15:0] poll, input int lat,
                          input bit noack, input int rdy_dly);
        int          exp_cnt, exp_acc, run_len, lim;
        int          accesses, cur_run, gap_len, idx, cyc, low;
        int          hold_err, rdy_err, run_err, gap_err, stab_err;
        bit          exp_to, exp_pf, done;
        logic [63:0] exp_dat;
        logic [7:0]  sel_exp;
        logic        we_exp;

        lim     = (poll == 16'd0) ? 1 : int'(poll);
        exp_to  = 1'b0;
        exp_pf  = 1'b0;
        exp_dat = '0;
        if (noack) begin
            exp_acc = 1; exp_cnt = 0; exp_to = 1'b1;
        end else if (mode == 2'd2) begin
            exp_cnt = lim; exp_pf = 1'b1;
            for (int i = 0; i < lim; i++) begin
                if (((rd_seq[i] ^ dat) & mask) == 64'd0) begin
                    exp_cnt = i + 1; exp_pf = 1'b0;
                    break;
                end
            end
            exp_acc = exp_cnt;
            exp_dat = rd_seq[exp_cnt - 1];
        end else begin
            exp_acc = 1; exp_cnt = 1;
            if (mode != 2'd0) exp_dat = rd_seq[0];
        end
        run_len = noack ? 16 : lat + 1;
        sel_exp = (mode == 2'd0) ? sel : 8'hff;
        we_exp  = (mode == 2'd0);

        @(negedge aclk);
        chk("cmd_ready_idle", 64'(s_cmd_ready), 64'd1);
        s_cmd_mode  = mode;  s_cmd_adr  = adr;  s_cmd_dat  = dat;
        s_cmd_mask  = mask;  s_cmd_sel  = sel;  s_cmd_wait = wt;
        s_cmd_poll  = poll;  s_cmd_valid = 1'b1;
        @(negedge aclk);
        s_cmd_valid = 1'b0;
        s_cmd_adr   = 37'({$urandom, $urandom});
        s_cmd_dat   = {$urandom, $urandom};
        s_cmd_mask  = {$urandom, $urandom};
        s_cmd_sel   = 8'($urandom);
        chk("stb_rise", 64'(m_wb_stb_o), 64'd1);

        accesses = 0; cur_run = 0; gap_len = 0; idx = 0; cyc = 0; done = 1'b0;
        hold_err = 0; rdy_err = 0; run_err = 0; gap_err = 0; stab_err = 0;
        while (!done && cyc < 2000) begin
            cyc++;
            if (m_wb_adr_o !== adr || m_wb_dat_o !== dat ||
                m_wb_sel_o !== sel_exp || m_wb_we_o !== we_exp) hold_err++;
            if (s_cmd_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
            if (m_wb_stb_o === 1'b1) begin
                if (cur_run == 0) begin
                    accesses++;
                    if (accesses > 1 && gap_len != 1) gap_err++;
                end
                cur_run++;
                if (!noack && cur_run == lat + 1) begin
                    m_wb_ack_i = 1'b1;
                    m_wb_dat_i = rd_seq[idx];
                    idx++;
                end else begin
                    m_wb_ack_i = 1'b0;
                    m_wb_dat_i = {$urandom, $urandom};
                end
            end else begin
                if (cur_run != 0) begin
                    if (cur_run != run_len) run_err++;
                    cur_run = 0;
                    gap_len = 0;
                end
                gap_len++;
                m_wb_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
                m_wb_dat_i = {$urandom, $urandom};
                if (m_rsp_valid === 1'b1) done = 1'b1;
            end
            if (!done) @(negedge aclk);
        end

        chk("rsp_arrived", 64'(done), 64'd1);
        chk("access_count", 64'(accesses), 64'(exp_acc));
        chk("stb_run_len", 64'(run_err), 64'd0);
        chk("stb_gap", 64'(gap_err), 64'd0);
        chk("wb_hold", 64'(hold_err), 64'd0);
        chk("busy_ready", 64'(rdy_err), 64'd0);
        chk("rsp_dat", m_rsp_dat, exp_dat);
        chk("rsp_we", 64'(m_rsp_we), 64'(we_exp));
        chk("rsp_timeout", 64'(m_rsp_timeout), 64'(exp_to));
        chk("rsp_poll_fail", 64'(m_rsp_poll_fail), 64'(exp_pf));
        chk("rsp_count", 64'(m_rsp_count), 64'(exp_cnt));

        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge aclk);
            m_wb_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_rsp_valid !== 1'b1 || m_rsp_dat !== exp_dat || m_rsp_we !== we_exp ||
                m_rsp_timeout !== exp_to || m_rsp_poll_fail !== exp_pf ||
                m_rsp_count !== 16'(exp_cnt) || m_wb_stb_o !== 1'b0) stab_err++;
        end
        chk("rsp_stable", 64'(stab_err), 64'd0);
        m_rsp_ready = 1'b1;
        @(negedge aclk);
        m_rsp_ready = 1'b0;
        m_wb_ack_i  = 1'b0;
        chk("rsp_valid_drop", 64'(m_rsp_valid), 64'd0);
        low = 0;
        while (s_cmd_ready !== 1'b1 && low <= int'(wt) + 4) begin
            low++;
            @(negedge aclk);
        end
        chk("wait_len", 64'(low), 64'(wt));
    endtask

    initial begin
        int          rst_err;
        logic [1:0]  r_mode;
        logic [63:0] r_dat, r_mask;
        int          r_poll;

        tests = 0; fails = 0; spurious = 1'b0;
        aresetn = 1'b0; s_cmd_valid = 1'b0; m_rsp_ready = 1'b0;
        m_wb_ack_i = 1'b0; m_wb_dat_i = '0;
        s_cmd_mode = '0; s_cmd_adr = '0; s_cmd_dat = '0; s_cmd_mask = '0;
        s_cmd_sel = '0; s_cmd_wait = '0; s_cmd_poll = '0;
        for (int i = 0; i < 16; i++) rd_seq[i] = '0;

        repeat (3) @(negedge aclk);
        chk("rst_stb", 64'(m_wb_stb_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(s_cmd_ready), 64'd0);
        chk("rst_adr", 64'(m_wb_adr_o), 64'd0);
        aresetn = 1'b1;

        // Write with ack in the third stb cycle.
        do_cmd(2'd0, 37'd9, 64'd1111, 64'd0, 8'hff, 16'd0, 16'd0, 2, 1'b0, 0);
        // Read returning 0x1234.
        rd_seq[0] = 64'h0000_0000_0000_1234;
        do_cmd(2'd1, 37'd0, 64'd0, 64'd0, 8'h00, 16'd0, 16'd0, 1, 1'b0, 1);
        // Poll for bit 0, which sets on the third read, with limit 8 and then 2.
        spurious = 1'b1;
        rd_seq[0] = 64'h2; rd_seq[1] = 64'h4; rd_seq[2] = 64'h5; rd_seq[3] = 64'h7;
        do_cmd(2'd2, 37'd5, 64'd1, 64'd1, 8'h00, 16'd0, 16'd8, 0, 1'b0, 0);
        do_cmd(2'd2, 37'd5, 64'd1, 64'd1, 8'h00, 16'd0, 16'd2, 0, 1'b0, 0);
        // Poll limit 0 behaves like a limit of 1.
        do_cmd(2'd2, 37'd5, 64'd1, 64'd1, 8'h00, 16'd0, 16'd0, 0, 1'b0, 0);
        // Slave never acks.
        do_cmd(2'd1, 37'd7, 64'd0, 64'd0, 8'h00, 16'd0, 16'd0, 0, 1'b1, 0);
        // Response held for 10 cycles, followed by a 5-cycle wait.
        rd_seq[0] = 64'hdead_beef_0bad_f00d;
        do_cmd(2'd3, 37'h1f_0000_0001, 64'd0, 64'd0, 8'h00, 16'd5, 16'd0, 3, 1'b0, 10);

        // Reset in the middle of a read's bus phase.
        @(negedge aclk);
        s_cmd_mode = 2'd1; s_cmd_adr = 37'd3; s_cmd_valid = 1'b1;
        @(negedge aclk);
        s_cmd_valid = 1'b0; m_wb_ack_i = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_mid_pre_stb", 64'(m_wb_stb_o), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_stb", 64'(m_wb_stb_o), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(s_cmd_ready), 64'd0);
        chk("rst_mid_adr", 64'(m_wb_adr_o), 64'd0);
        chk("rst_mid_sel", 64'(m_wb_sel_o), 64'd0);
        chk("rst_mid_rsp_cnt", 64'(m_rsp_count), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        rst_err = 0;
        repeat (20) begin
            @(negedge aclk);
            if (m_rsp_valid !== 1'b0 || m_wb_stb_o !== 1'b0) rst_err++;
        end
        chk("rst_no_rsp", 64'(rst_err), 64'd0);
        do_cmd(2'd0, 37'd12, 64'h0123_4567_89ab_cdef, 64'd0, 8'h0f, 16'd0, 16'd0, 1, 1'b0, 0);

        // Randomized commands.
        for (int n = 0; n < 25; n++) begin
            r_mode = 2'($urandom_range(0, 3));
            r_dat  = {$urandom, $urandom};
            r_mask = {$urandom, $urandom} & {$urandom, $urandom};
            r_poll = $urandom_range(0, 6);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 2) == 0)
                    rd_seq[i] = (r_dat & r_mask) | ({$urandom, $urandom} & ~r_mask);
                else
                    rd_seq[i] = {$urandom, $urandom};
            end
            do_cmd(r_mode, 37'({$urandom, $urandom}), r_dat, r_mask, 8'($urandom),
                   16'($urandom_range(0, 4)), 16'(r_poll), $urandom_range(0, 4),
                   ($urandom_range(0, 9) == 0), $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jelly_wishbone_master_sequencer.md
JELLY_WISHBONE_MASTER_SEQUENCER -- requirements
Module: jelly_wishbone_master_sequencer

Interface
REQ-001 SHALL have parameter WB_ADR_WIDTH, default 37: Wishbone word-address width.
REQ-002 SHALL have parameter WB_DAT_WIDTH, default 64: Wishbone data width.
REQ-003 SHALL have parameter WB_SEL_WIDTH, default WB_DAT_WIDTH/8: byte-select width.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum bus cycles without ack; 0 disables the timeout.
REQ-005 SHALL have parameter WAIT_WIDTH, default 16: width of the per-command post-delay field.
REQ-006 SHALL have parameter POLL_WIDTH, default 16: width of the poll-retry limit field.
REQ-007 Ports (one clock; reset is asynchronous and active-low):
  aresetn  in  1  asynchronous active-low reset
  aclk  in  1  clock
  s_cmd_mode  in  2  0=write, 1=read, 2=poll, 3=reserved (treated as read)
  s_cmd_adr  in  WB_ADR_WIDTH  word address
  s_cmd_dat  in  WB_DAT_WIDTH  write data / poll expect value
  s_cmd_mask  in  WB_DAT_WIDTH  poll compare mask
  s_cmd_sel  in  WB_SEL_WIDTH  byte select (reads and polls use all-ones)
  s_cmd_wait  in  WAIT_WIDTH  idle cycles after response handshake
  s_cmd_poll  in  POLL_WIDTH  poll read limit (0 treated as 1)
  s_cmd_valid  in  1  command valid
  s_cmd_ready  out  1  command ready
  m_rsp_dat  out  WB_DAT_WIDTH  last read data (0 for writes)
  m_rsp_we  out  1  command was a write
  m_rsp_timeout  out  1  bus timeout occurred
  m_rsp_poll_fail  out  1  poll limit reached without a match
  m_rsp_count  out  POLL_WIDTH  number of bus accesses issued
  m_rsp_valid  out  1  response valid
  m_rsp_ready  in  1  response ready
  m_wb_adr_o/dat_o/sel_o/we_o/stb_o  out  per params  Wishbone master outputs
  m_wb_dat_i/ack_i  in  per params  Wishbone master inputs
  busy  out  1  high in any state other than IDLE

Function
REQ-008 SHALL implement states IDLE, BUS, GAP, RESP and WAIT; all outputs SHALL be registered except s_cmd_ready = (state==IDLE) & aresetn.
REQ-009 IDLE: on s_cmd_valid&s_cmd_ready SHALL capture all command fields, clear the access count, and enter BUS; m_wb_stb_o SHALL rise on the next cycle.
REQ-010 BUS: m_wb_stb_o=1; adr/dat/sel/we SHALL be held stable; we=1 only for mode 0.
REQ-011 An ack sampled in BUS SHALL drop stb on the next cycle and increment the access count; for reads and polls it SHALL capture m_wb_dat_i.
REQ-012 Write or read with ack SHALL go to RESP.
REQ-013 Poll with ack: if (m_wb_dat_i & mask)==(dat & mask) SHALL go to RESP with poll_fail=0; else if the access count equals the limit SHALL go to RESP with poll_fail=1; else SHALL go to GAP.
REQ-014 GAP SHALL last exactly one cycle with stb=0, then return to BUS.
REQ-015 With TIMEOUT>0, a counter SHALL count BUS cycles without ack; after TIMEOUT such cycles stb SHALL drop and the state SHALL go to RESP with timeout=1; the counter SHALL reload on each BUS entry.
REQ-016 RESP: m_rsp_valid=1 and all m_rsp_* fields SHALL be held until m_rsp_ready; after the handshake the state SHALL go to WAIT if wait>0, else IDLE.
REQ-017 WAIT SHALL last exactly wait cycles, then go to IDLE.
REQ-018 Back-to-back commands (wait=0) SHALL yield at least one cycle of stb=0 between accesses.
REQ-019 When stb=0, adr/dat/sel/we SHALL hold their last values and SHALL never drive X.
REQ-020 An ack while stb=0 SHALL be ignored.

Reset
REQ-021 aresetn low SHALL immediately and asynchronously force: state=IDLE, stb=0, we=0, adr/dat/sel=0, m_rsp_valid=0, all rsp fields=0, busy=0, counters=0.
REQ-022 Reset mid-BUS SHALL abandon the transaction with no response; the first command after release SHALL behave as from power-up.

Verification
REQ-023 Write adr=9, dat=1111, sel=8'hff, ack 2 cycles after stb -> exactly one access with stb high 3 cycles; rsp we=1, dat=0, count=1, timeout=0.
REQ-024 Read adr=0, slave returns 64'h0000_0000_0000_1234 -> rsp dat=64'h1234, we=0, count=1; s_cmd_ready low from acceptance until the rsp handshake.
REQ-025 Poll adr=5, mask=1, expect=1, limit=8, bit 0 sets on the 3rd read -> 3 accesses, each separated by 1 stb-low cycle; rsp count=3, poll_fail=0. Same command with limit=2 -> count=2, poll_fail=1.
REQ-026 TIMEOUT=16, slave never acks -> stb high exactly 16 cycles, then rsp timeout=1, count=0.
REQ-027 m_rsp_ready held low 10 cycles, then wait=5 -> rsp fields stable for all 10 cycles; s_cmd_ready rises exactly 5 cycles after the handshake.
REQ-028 aresetn asserted during BUS of a read -> stb low in the same cycle, no response; a following write completes normally.
